matmul_ctrl: RTL and testbench

- Sequencer for the 8x8 signed matrix multiply C = A x B.
- Drives the two read ports of the 64x8 A and B operand RAMs, accumulates dot products at full precision, and streams the 64 results into the C result RAM.
- Sits between the top-level start/done control and the three RAMs.
- Never writes A or B; the operand RAMs' write enables are held low outside this block.

---
 rtl/matmul_ctrl.sv | 165 ++++++++++++++++
 tb/tb_matmul_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_ctrl.sv
// ---------------------------------------------------------------------------
// matmul_ctrl
//   Sequencer for the 8x8 signed matrix multiply C = A x B.
//   It issues two A reads and two B reads per cycle, covering one k-pair of
//   one dot product per issue slot, so each result takes four slots. Slots
//   run back to back. Dot products accumulate at full precision, and each
//   finished element is written into the C RAM with a single-cycle strobe.
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   start               begin a multiply (sampled only in IDLE)
//   a_addr1/2, b_addr1/2  registered operand RAM read addresses
//   a_data1/2, b_data1/2  operand RAM read data (signed, 1-cycle latency)
//   c_addr, c_data, c_we  registered C RAM write port
//   busy                first issue cycle through last write
//   done                single-cycle completion pulse
// ---------------------------------------------------------------------------
module matmul_ctrl #(
  parameter int ACC_W = 19  // >= 19 keeps the all -128 case exact
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  output logic [5:0]       a_addr1,
  output logic [5:0]       a_addr2,
  input  logic [7:0]       a_data1,
  input  logic [7:0]       a_data2,
  output logic [5:0]       b_addr1,
  output logic [5:0]       b_addr2,
  input  logic [7:0]       b_data1,
  input  logic [7:0]       b_data2,
  output logic [5:0]       c_addr,
  output logic [ACC_W-1:0] c_data,
  output logic             c_we,
  output logic             busy,
  output logic             done
);

  // Stage 1: addresses on the RAM pins. Stage 2: RAM data returned.
  localparam int STAGES = 2;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [7:0]        slot_q, slot_d;     // slot n = {i, j, p}
  logic              drain_q, drain_d;
  logic              issue;

  logic [STAGES:1]   vld_pipe_q;
  logic [7:0]        s1_slot_q, s2_slot_q;

  logic [5:0]        a_addr1_q, a_addr2_q, b_addr1_q, b_addr2_q;
  logic [5:0]        c_addr_q;
  logic [ACC_W-1:0]  c_data_q;
  logic              c_we_q, busy_q, done_q;
  logic signed [ACC_W-1:0] acc_q;

  logic signed [15:0]      prod1, prod2;
  logic signed [ACC_W-1:0] pair_sum, acc_sum;
  logic [1:0]              s2_p;
  logic                    last_pair;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      slot_q  <= '0;
      drain_q <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      drain_q <= drain_d;
    end
  end

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    drain_d = drain_q;
    issue   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          slot_d  = '0;
        end
      end
      S_RUN: begin
        issue  = 1'b1;
        slot_d = slot_q + 8'd1;
        if (slot_q == 8'd255) begin
          state_d = S_DRAIN;
          drain_d = 1'b0;
        end
      end
      // Two cycles let the last slot's data return and its write land.
      S_DRAIN: begin
        drain_d = 1'b1;
        if (drain_q) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- Datapath ----------------
  assign prod1     = $signed(a_data1) * $signed(b_data1);
  assign prod2     = $signed(a_data2) * $signed(b_data2);
  assign pair_sum  = ACC_W'(prod1) + ACC_W'(prod2);
  assign acc_sum   = acc_q + pair_sum;
  assign s2_p      = s2_slot_q[1:0];
  assign last_pair = vld_pipe_q[STAGES] && (s2_p == 2'd3);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe_q <= '0;
      s1_slot_q  <= '0;
      s2_slot_q  <= '0;
      a_addr1_q  <= '0;
      a_addr2_q  <= '0;
      b_addr1_q  <= '0;
      b_addr2_q  <= '0;
      c_addr_q   <= '0;
      c_data_q   <= '0;
      c_we_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      acc_q      <= '0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[STAGES-1:1], issue};
      s1_slot_q  <= slot_q;
      s2_slot_q  <= s1_slot_q;

      // i = slot[7:5], j = slot[4:2], p = slot[1:0]; idle addresses sit at 0.
      a_addr1_q  <= issue ? {slot_q[7:5], slot_q[1:0], 1'b0} : 6'd0;
      a_addr2_q  <= issue ? {slot_q[7:5], slot_q[1:0], 1'b1} : 6'd0;
      b_addr1_q  <= issue ? {slot_q[1:0], 1'b0, slot_q[4:2]} : 6'd0;
      b_addr2_q  <= issue ? {slot_q[1:0], 1'b1, slot_q[4:2]} : 6'd0;

      busy_q     <= issue | (|vld_pipe_q);
      done_q     <= (state_q == S_DONE);

      // p=0 overwrites, so no clear cycle is needed between elements.
      if (vld_pipe_q[STAGES]) begin
        if (s2_p == 2'd0)      acc_q <= pair_sum;
        else if (s2_p != 2'd3) acc_q <= acc_sum;
      end

      c_we_q   <= last_pair;
      c_addr_q <= last_pair ? s2_slot_q[7:2] : 6'd0;
      c_data_q <= last_pair ? acc_sum : '0;
    end
  end

  assign a_addr1 = a_addr1_q;
  assign a_addr2 = a_addr2_q;
  assign b_addr1 = b_addr1_q;
  assign b_addr2 = b_addr2_q;
  assign c_addr  = c_addr_q;
  assign c_data  = c_data_q;
  assign c_we    = c_we_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_matmul_ctrl.sv
// Bench for matmul_ctrl: behavioural RAMs, a negedge monitor logging writes,
// done pulses and busy cycles, and an arithmetic reference for C = A x B.
module tb_matmul_ctrl;
  localparam int ACC_W = 19;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             start = 1'b0;
  logic [5:0]       a_addr1, a_addr2, b_addr1, b_addr2, c_addr;
  logic [7:0]       a_data1, a_data2, b_data1, b_data2;
  logic [ACC_W-1:0] c_data;
  logic             c_we, busy, done;

  int checks = 0;
  int errors = 0;

  logic signed [7:0] A [64];
  logic signed [7:0] B [64];
  int exp_c [64];

  int edge_cnt = 0;
  int wr_cyc[$], wr_addr[$], wr_data[$];
  int done_cyc[$], done_busy[$], busy_cyc[$];

  matmul_ctrl #(.ACC_W(ACC_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .a_addr1(a_addr1), .a_addr2(a_addr2), .a_data1(a_data1), .a_data2(a_data2),
    .b_addr1(b_addr1), .b_addr2(b_addr2), .b_data1(b_data1), .b_data2(b_data2),
    .c_addr(c_addr), .c_data(c_data), .c_we(c_we), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Synchronous-read operand RAMs, one cycle of latency.
  always @(posedge clk) begin
    a_data1 <= A[a_addr1];
    a_data2 <= A[a_addr2];
    b_data1 <= B[b_addr1];
    b_data2 <= B[b_addr2];
  end

  // At a negedge, edge_cnt is the index of the edge that opened this cycle.
  always @(negedge clk) begin
    if (c_we) begin
      wr_cyc.push_back(edge_cnt);
      wr_addr.push_back(int'(c_addr));
      wr_data.push_back(int'($signed(c_data)));
    end
    if (done) begin
      done_cyc.push_back(edge_cnt);
      done_busy.push_back(int'(busy));
    end
    if (busy) busy_cyc.push_back(edge_cnt);
  end

  function automatic void model();
    for (int e = 0; e < 64; e++) begin
      int s = 0;
      for (int k = 0; k < 8; k++)
        s += int'(A[8*(e/8)+k]) * int'(B[8*k+(e%8)]);
      exp_c[e] = s;
    end
  endfunction

  task automatic fill_random();
    for (int x = 0; x < 64; x++) begin
      A[x] = 8'($urandom);
      B[x] = 8'($urandom);
    end
    model();
  endtask

  // Returns t0, the edge index at which start is sampled (cycle 0).
  task automatic start_run(output int t0);
    @(negedge clk);
    start = 1'b1;
    t0 = edge_cnt + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (done_cyc.size() >= n) break;
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({a_addr1, a_addr2, b_addr1, b_addr2, c_addr} !== 30'd0) begin
      errors++; $display("FAIL reset_addr got %0h exp 0", {a_addr1, a_addr2, b_addr1, b_addr2, c_addr});
    end
    checks++;
    if (c_data !== '0) begin errors++; $display("FAIL reset_cdata got %0d exp 0", c_data); end
    checks++;
    if ({c_we, busy, done} !== 3'b000) begin
      errors++; $display("FAIL reset_ctrl got %b exp 000", {c_we, busy, done});
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({c_we, busy, done} !== 3'b000) begin
      errors++; $display("FAIL idle_ctrl got %b exp 000", {c_we, busy, done});
    end
  endtask

  task automatic test_identity();
    int t0, wb, db, bb, nb;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        A[8*r+c] = (r == c) ? 8'sd1 : 8'sd0;
        B[8*r+c] = 8'(8*r + c - 32);
      end
    wb = wr_cyc.size(); db = done_cyc.size(); bb = busy_cyc.size();
    start_run(t0);
    wait_done(db + 1, 400);
    checks++;
    if (wr_cyc.size() - wb !== 64) begin
      errors++; $display("FAIL ident_wcount got %0d exp 64", wr_cyc.size() - wb);
    end
    for (int e = 0; e < 64 && wb + e < wr_cyc.size(); e++) begin
      checks++;
      if (wr_addr[wb+e] !== e || wr_data[wb+e] !== int'(B[e])) begin
        errors++; $display("FAIL ident_c[%0d] got addr %0d data %0d exp addr %0d data %0d",
                           e, wr_addr[wb+e], wr_data[wb+e], e, int'(B[e]));
      end
      checks++;
      if (wr_cyc[wb+e] !== t0 + 4*e + 6) begin
        errors++; $display("FAIL ident_wtime[%0d] got %0d exp %0d", e, wr_cyc[wb+e] - t0, 4*e + 6);
      end
    end
    checks++;
    if (done_cyc.size() !== db + 1 || done_cyc[db] !== t0 + 259 || done_busy[db] !== 0) begin
      errors++; $display("FAIL ident_done got %0d pulses first at %0d exp 1 pulse at 259 busy low",
                         done_cyc.size() - db, (done_cyc.size() > db) ? done_cyc[db] - t0 : -1);
    end
    nb = busy_cyc.size() - bb;
    checks++;
    if (nb !== 258 || busy_cyc[bb] !== t0 + 1 || busy_cyc[bb+nb-1] !== t0 + 258) begin
      errors++; $display("FAIL ident_busy got %0d cycles from %0d to %0d exp 258 from 1 to 258", nb,
                         (nb > 0) ? busy_cyc[bb] - t0 : -1, (nb > 0) ? busy_cyc[bb+nb-1] - t0 : -1);
    end
  endtask

  task automatic test_extremes();
    for (int pass = 0; pass < 2; pass++) begin
      int t0, wb, db, expv;
      for (int x = 0; x < 64; x++) begin
        A[x] = -8'sd128;
        B[x] = (pass == 0) ? -8'sd128 : 8'sd127;
      end
      expv = (pass == 0) ? 131072 : -130048;
      wb = wr_cyc.size(); db = done_cyc.size();
      start_run(t0);
      wait_done(db + 1, 400);
      checks++;
      if (wr_cyc.size() - wb !== 64) begin
        errors++; $display("FAIL extreme%0d_wcount got %0d exp 64", pass, wr_cyc.size() - wb);
      end
      for (int e = 0; e < 64 && wb + e < wr_cyc.size(); e++) begin
        checks++;
        if (wr_data[wb+e] !== expv) begin
          errors++; $display("FAIL extreme%0d_c[%0d] got %0d exp %0d", pass, e, wr_data[wb+e], expv);
        end
      end
    end
  endtask

  task automatic test_addr_trace();
    int t0, wb, db;
    fill_random();
    wb = wr_cyc.size(); db = done_cyc.size();
    start_run(t0);
    for (int k = 1; k <= 256; k++) begin
      int n, e, p, i, j;
      @(negedge clk);
      n = k - 1; e = n / 4; p = n % 4; i = e / 8; j = e % 8;
      checks++;
      if (edge_cnt !== t0 + k || a_addr1 !== 6'(8*i + 2*p) || a_addr2 !== 6'(8*i + 2*p + 1) ||
          b_addr1 !== 6'(16*p + j) || b_addr2 !== 6'(16*p + 8 + j)) begin
        errors++; $display("FAIL addr_slot%0d got a %0d/%0d b %0d/%0d exp a %0d/%0d b %0d/%0d", n,
                           a_addr1, a_addr2, b_addr1, b_addr2, 8*i+2*p, 8*i+2*p+1, 16*p+j, 16*p+8+j);
      end
      if (k == 6) begin
        checks++;
        if ({a_addr1, a_addr2, b_addr1, b_addr2} !== {6'd2, 6'd3, 6'd17, 6'd25}) begin
          errors++; $display("FAIL addr_cycle6 got a %0d/%0d b %0d/%0d exp a 2/3 b 17/25",
                             a_addr1, a_addr2, b_addr1, b_addr2);
        end
      end
    end
    wait_done(db + 1, 400);
    checks++;
    if (wr_cyc.size() - wb !== 64) begin
      errors++; $display("FAIL rand_wcount got %0d exp 64", wr_cyc.size() - wb);
    end
    for (int e = 0; e < 64 && wb + e < wr_cyc.size(); e++) begin
      checks++;
      if (wr_addr[wb+e] !== e || wr_data[wb+e] !== exp_c[e]) begin
        errors++; $display("FAIL rand_c[%0d] got addr %0d data %0d exp data %0d",
                           e, wr_addr[wb+e], wr_data[wb+e], exp_c[e]);
      end
    end
  endtask

  task automatic test_start_held();
    int t0, wb, db, nd;
    fill_random();
    wb = wr_cyc.size(); db = done_cyc.size();
    @(negedge clk);
    start = 1'b1;
    t0 = edge_cnt + 1;
    repeat (600) @(negedge clk);
    start = 1'b0;
    nd = 0;
    for (int x = db; x < done_cyc.size(); x++)
      if (done_cyc[x] <= t0 + 599) nd++;
    checks++;
    if (nd !== 2 || done_cyc[db] !== t0 + 259 || done_cyc[db+1] !== t0 + 519) begin
      errors++; $display("FAIL held_done got %0d pulses exp 2 at 259 and 519", nd);
    end
    checks++;
    if (wr_cyc.size() - wb < 65 || wr_cyc[wb+64] !== t0 + 266) begin
      errors++; $display("FAIL held_run2_first_we got %0d exp 266",
                         (wr_cyc.size() - wb > 64) ? wr_cyc[wb+64] - t0 : -1);
    end
    // The third start (cycle 520) was legitimately taken; let it finish.
    wait_done(db + 3, 400);
    checks++;
    if (wr_cyc.size() - wb !== 192 || done_cyc.size() - db !== 3) begin
      errors++; $display("FAIL held_total got %0d writes %0d done exp 192 and 3",
                         wr_cyc.size() - wb, done_cyc.size() - db);
    end
    for (int x = 0; x < 192 && wb + x < wr_cyc.size(); x++) begin
      checks++;
      if (wr_addr[wb+x] !== x % 64 || wr_data[wb+x] !== exp_c[x%64]) begin
        errors++; $display("FAIL held_c[%0d] got addr %0d data %0d exp addr %0d data %0d",
                           x, wr_addr[wb+x], wr_data[wb+x], x % 64, exp_c[x%64]);
      end
    end
  endtask

  task automatic test_start_ignored();
    int t0, wb, db;
    fill_random();
    wb = wr_cyc.size(); db = done_cyc.size();
    start_run(t0);
    while (edge_cnt < t0 + 99) @(negedge clk);
    start = 1'b1;               // sampled at cycle 100, mid-RUN
    @(negedge clk);
    start = 1'b0;
    wait_done(db + 1, 400);
    repeat (20) @(negedge clk);
    checks++;
    if (wr_cyc.size() - wb !== 64 || done_cyc.size() - db !== 1) begin
      errors++; $display("FAIL ignored_counts got %0d writes %0d done exp 64 and 1",
                         wr_cyc.size() - wb, done_cyc.size() - db);
    end
    for (int e = 0; e < 64 && wb + e < wr_cyc.size(); e++) begin
      checks++;
      if (wr_cyc[wb+e] !== t0 + 4*e + 6 || wr_data[wb+e] !== exp_c[e]) begin
        errors++; $display("FAIL ignored_c[%0d] got cyc %0d data %0d exp cyc %0d data %0d",
                           e, wr_cyc[wb+e] - t0, wr_data[wb+e], 4*e + 6, exp_c[e]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int t0, wb, db;
    fill_random();
    wb = wr_cyc.size(); db = done_cyc.size();
    start_run(t0);
    while (edge_cnt < t0 + 120) @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++;
    if ({c_we, busy, done} !== 3'b000 || c_data !== '0 ||
        {a_addr1, a_addr2, b_addr1, b_addr2, c_addr} !== 30'd0) begin
      errors++; $display("FAIL midreset_outputs got we/busy/done %b exp 000 and zero buses",
                         {c_we, busy, done});
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (300) @(negedge clk);
    checks++;
    if (wr_cyc.size() - wb !== 29 || done_cyc.size() !== db) begin
      errors++; $display("FAIL midreset_partial got %0d writes %0d done exp 29 and 0",
                         wr_cyc.size() - wb, done_cyc.size() - db);
    end
    for (int e = 0; e < 29 && wb + e < wr_cyc.size(); e++) begin
      checks++;
      if (wr_addr[wb+e] !== e || wr_data[wb+e] !== exp_c[e]) begin
        errors++; $display("FAIL midreset_pre_c[%0d] got data %0d exp %0d", e, wr_data[wb+e], exp_c[e]);
      end
    end
    // Fresh start after the abort must produce a complete, correct run.
    fill_random();
    wb = wr_cyc.size(); db = done_cyc.size();
    start_run(t0);
    wait_done(db + 1, 400);
    checks++;
    if (wr_cyc.size() - wb !== 64 || done_cyc.size() - db !== 1 || done_cyc[db] !== t0 + 259) begin
      errors++; $display("FAIL restart_counts got %0d writes %0d done exp 64 and 1 at 259",
                         wr_cyc.size() - wb, done_cyc.size() - db);
    end
    for (int e = 0; e < 64 && wb + e < wr_cyc.size(); e++) begin
      checks++;
      if (wr_addr[wb+e] !== e || wr_data[wb+e] !== exp_c[e] || wr_cyc[wb+e] !== t0 + 4*e + 6) begin
        errors++; $display("FAIL restart_c[%0d] got addr %0d data %0d exp addr %0d data %0d",
                           e, wr_addr[wb+e], wr_data[wb+e], e, exp_c[e]);
      end
    end
  endtask

  initial begin
    for (int x = 0; x < 64; x++) begin A[x] = '0; B[x] = '0; end
    test_reset();
    test_identity();
    test_extremes();
    test_addr_trace();
    test_start_held();
    test_start_ignored();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at edge %0d", edge_cnt);
    $fatal(1, "watchdog");
  end

endmodule
